// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Write-back stage and 2**ADDR_W-entry architectural register file for the
// 5-stage MIPS pipeline.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   MemtoReg, RegWrite   MEM/WB control: data select and write enable
//   MemData, ALU_result  MEM/WB data candidates for write-back
//   WriteReg             destination register index
//   ReadReg1/2           ID-stage source indices (rs, rt)
//   ReadData1/2          ID-stage read values; the in-flight write is bypassed
//                        when BYPASS=1
//   WriteData            selected write-back value for EX forwarding
//   wb_valid             current WB instruction commits a register write
//   dbg_addr, dbg_data   debug read port; array contents only, no bypass
//   wb_count             number of committed register writes (wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] MemData,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData,
  output logic              wb_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wb_count
);

  localparam int                NREG   = 2 ** ADDR_W;
  localparam bit                BYP_EN = (BYPASS != 32'sd0);
  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // Write-back data select and commit qualifier (register 0 never commits).
  always_comb begin
    if (MemtoReg) begin
      WriteData = MemData;
    end else begin
      WriteData = ALU_result;
    end
    wb_valid = RegWrite && (WriteReg != ZERO_A);
  end

  // Next-state of the array and the retired-write counter.
  always_comb begin
    regs_d = regs_q;
    if (wb_valid) begin
      regs_d[WriteReg] = WriteData;
      cnt_d            = cnt_q + ONE_C;
    end else begin
      cnt_d            = cnt_q;
    end
    // Entry 0 is pinned to zero so it can never hold anything else.
    regs_d[0] = ZERO_D;
  end

  // Array and counter state; reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= ZERO_D;
      end
      cnt_q <= ZERO_C;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  // ID read ports: index 0 forces zero; otherwise the in-flight write is
  // forwarded ahead of the array so ID never sees the pre-write value.
  always_comb begin
    if (ReadReg1 == ZERO_A) begin
      ReadData1 = ZERO_D;
    end else if (BYP_EN && wb_valid && (WriteReg == ReadReg1)) begin
      ReadData1 = WriteData;
    end else begin
      ReadData1 = regs_q[ReadReg1];
    end

    if (ReadReg2 == ZERO_A) begin
      ReadData2 = ZERO_D;
    end else if (BYP_EN && wb_valid && (WriteReg == ReadReg2)) begin
      ReadData2 = WriteData;
    end else begin
      ReadData2 = regs_q[ReadReg2];
    end
  end

  // Debug port reads committed state only.
  always_comb begin
    if (dbg_addr == ZERO_A) begin
      dbg_data = ZERO_D;
    end else begin
      dbg_data = regs_q[dbg_addr];
    end
  end

  assign wb_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Self-checking bench for wb_regfile. Two instances share all inputs:
//   u_byp : BYPASS=1, CNT_W=32
//   u_nb  : BYPASS=0, CNT_W=4 (no-bypass reads and counter wrap)
// A behavioural model produces expected values that are queued when stimulus
// is driven and compared when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        MemtoReg;
  logic        RegWrite;
  logic [31:0] MemData;
  logic [31:0] ALU_result;
  logic [4:0]  WriteReg;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  dbg_addr;

  logic [31:0] b_rd1, b_rd2, b_wd, b_dbg, b_cnt;
  logic        b_val;
  logic [31:0] n_rd1, n_rd2, n_wd, n_dbg;
  logic        n_val;
  logic [3:0]  n_cnt;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(32)) u_byp (
    .clk(clk), .rst_n(rst_n), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemData(MemData), .ALU_result(ALU_result), .WriteReg(WriteReg),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(b_rd1),
    .ReadData2(b_rd2), .WriteData(b_wd), .wb_valid(b_val),
    .dbg_addr(dbg_addr), .dbg_data(b_dbg), .wb_count(b_cnt)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(4)) u_nb (
    .clk(clk), .rst_n(rst_n), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemData(MemData), .ALU_result(ALU_result), .WriteReg(WriteReg),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(n_rd1),
    .ReadData2(n_rd2), .WriteData(n_wd), .wb_valid(n_val),
    .dbg_addr(dbg_addr), .dbg_data(n_dbg), .wb_count(n_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] mregs [32];
  logic [31:0] mcnt;
  int          n_checks;
  int          n_pass;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return b_rd1;
      1:       return b_rd2;
      2:       return b_wd;
      3:       return {31'd0, b_val};
      4:       return b_dbg;
      5:       return b_cnt;
      6:       return n_rd1;
      7:       return n_rd2;
      8:       return n_dbg;
      9:       return {28'd0, n_cnt};
      10:      return n_wd;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic flush();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcnt = 32'd0;
  endtask

  // One MEM/WB instruction: drive at negedge, check pre-edge outputs, then
  // check committed state after the rising edge.
  task automatic wb_cycle(input logic rw, input logic m2r, input logic [31:0] md,
                          input logic [31:0] alu, input logic [4:0] wr,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] da);
    logic [31:0] wd;
    logic        v;
    @(negedge clk);
    RegWrite = rw; MemtoReg = m2r; MemData = md; ALU_result = alu;
    WriteReg = wr; ReadReg1 = r1; ReadReg2 = r2; dbg_addr = da;
    wd = m2r ? md : alu;
    v  = rw && (wr != 5'd0);
    #1;
    push("wdata", 2, wd);
    push("wdata_nb", 10, wd);
    push("wb_valid", 3, {31'd0, v});
    push("rd1", 0, (r1 == 5'd0) ? 32'd0 : ((v && wr == r1) ? wd : mregs[r1]));
    push("rd2", 1, (r2 == 5'd0) ? 32'd0 : ((v && wr == r2) ? wd : mregs[r2]));
    push("rd1_nb", 6, mregs[r1]);
    push("rd2_nb", 7, mregs[r2]);
    push("dbg_pre", 4, mregs[da]);
    push("dbg_pre_nb", 8, mregs[da]);
    flush();
    @(posedge clk);
    if (v) begin
      mregs[wr] = wd;
      mcnt = mcnt + 32'd1;
    end
    #1;
    push("dbg_post", 4, mregs[da]);
    push("dbg_post_nb", 8, mregs[da]);
    push("count", 5, mcnt);
    push("count_nb", 9, mcnt & 32'h0000_000F);
    flush();
  endtask

  task automatic expect_all_zero(input string tag);
    push({tag, "_rd1"}, 0, 32'd0);
    push({tag, "_rd2"}, 1, 32'd0);
    push({tag, "_dbg"}, 4, 32'd0);
    push({tag, "_cnt"}, 5, 32'd0);
    push({tag, "_rd1_nb"}, 6, 32'd0);
    push({tag, "_dbg_nb"}, 8, 32'd0);
    push({tag, "_cnt_nb"}, 9, 32'd0);
    flush();
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_clear();
    rst_n = 1'b0;
    RegWrite = 1'b0; MemtoReg = 1'b0; MemData = 32'd0; ALU_result = 32'd0;
    WriteReg = 5'd0; ReadReg1 = 5'd1; ReadReg2 = 5'd2; dbg_addr = 5'd3;
    #2;
    expect_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write-back, then load write-back.
    wb_cycle(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd8, 5'd8, 5'd0, 5'd8);
    wb_cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 5'd9, 5'd9, 5'd8, 5'd9);
    // Register-0 protection (ReadReg1 = 0 throughout).
    wb_cycle(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 5'd0);
    // Same-cycle bypass on both ports; no-bypass instance returns old value.
    wb_cycle(1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd5, 5'd1, 5'd2, 5'd5);
    wb_cycle(1'b1, 1'b0, 32'h0, 32'h0000_0022, 5'd5, 5'd5, 5'd5, 5'd5);
    // One port bypasses, the other reads the array.
    wb_cycle(1'b1, 1'b1, 32'h0000_0033, 32'h0, 5'd5, 5'd9, 5'd5, 5'd8);
    // Write disabled: no change, WriteData still reflects the mux.
    wb_cycle(1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd7, 5'd7, 5'd7, 5'd7);
    wb_cycle(1'b0, 1'b0, 32'h0, 32'h0000_00AA, 5'd7, 5'd7, 5'd7, 5'd7);

    // Random traffic; drives the 4-bit counter past 0xF -> 0.
    for (int i = 0; i < 20; i++) begin
      wb_cycle(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Mid-cycle reset: outputs clear immediately, no clock edge needed.
    @(negedge clk);
    RegWrite = 1'b0; ReadReg1 = 5'd8; ReadReg2 = 5'd9; dbg_addr = 5'd5;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    expect_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      wb_cycle(1'b0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(i), 5'(31 - i), 5'(i));
    end

    // Reset coincident with a write edge: reset wins.
    wb_cycle(1'b1, 1'b0, 32'h0, 32'h0000_0044, 5'd4, 5'd4, 5'd4, 5'd4);
    @(negedge clk);
    RegWrite = 1'b1; MemtoReg = 1'b0; ALU_result = 32'h0000_0055;
    WriteReg = 5'd3; ReadReg1 = 5'd4; ReadReg2 = 5'd1; dbg_addr = 5'd3;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    RegWrite = 1'b0;
    #1;
    expect_all_zero("rst_race");
    @(negedge clk);
    rst_n = 1'b1;
    wb_cycle(1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd4, 5'd3);
    wb_cycle(1'b1, 1'b0, 32'h0, 32'h0000_0066, 5'd3, 5'd3, 5'd0, 5'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back stage and architectural register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32-entry register file. It serves the ID stage's two read ports, with a same-cycle write-to-read bypass so that ID never reads a stale value. It also exports the write-back value for EX forwarding, a debug read port, and a retired-write counter.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register index width; the file holds 2**ADDR_W entries
BYPASS, 1, 1 enables the internal WB-to-ID write-through bypass; 0 returns array contents only
CNT_W, 32, width of the retired-write counter

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
MemtoReg  input  1  from MEM/WB; 1 selects MemData, 0 selects ALU_result
RegWrite  input  1  from MEM/WB; write-enable for this instruction
MemData  input  DATA_W  from MEM/WB; load data
ALU_result  input  DATA_W  from MEM/WB; ALU result
WriteReg  input  ADDR_W  from MEM/WB; destination register index
ReadReg1  input  ADDR_W  ID-stage source index rs
ReadReg2  input  ADDR_W  ID-stage source index rt
ReadData1  output  DATA_W  value of register rs
ReadData2  output  DATA_W  value of register rt
WriteData  output  DATA_W  selected write-back value, sent to the EX forwarding mux
wb_valid  output  1  high when the current WB instruction commits a write
dbg_addr  input  ADDR_W  debug read index
dbg_data  output  DATA_W  debug read value; never bypassed
wb_count  output  CNT_W  number of committed register writes

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0): all register entries are cleared to 0 immediately and wb_count is cleared to 0, without waiting for a clock edge. Combinational outputs follow the cleared contents.
- On release of reset, the first write commits at the first rising edge of clk where the commit condition holds.
- Write-back mux: WriteData = MemtoReg ? MemData : ALU_result. This is purely combinational with zero latency.
- Commit condition: wb_valid = RegWrite && (WriteReg != 0). This is combinational.
- Write: on the rising edge of clk, if wb_valid is high, reg[WriteReg] <= WriteData. When RegWrite=0, nothing is written regardless of the other inputs.
- Register 0: hardwired to zero.
  - A write to register 0 is discarded and wb_count does not increment.
  - Reads of index 0 always return 0 on all ports, including the bypass path.
- Read ports: asynchronous and combinational from the array.
- Bypass (BYPASS=1): if wb_valid && WriteReg == ReadRegN, then ReadDataN = WriteData in the same cycle, before the commit edge.
  - Each port is evaluated independently; both ports may bypass simultaneously.
  - With BYPASS=0, the array value is returned, which is pre-write until the edge.
- Debug port: dbg_data = reg[dbg_addr] from the array only, with no bypass. Index 0 reads 0.
- Counter: wb_count increments by 1 on each rising edge where wb_valid=1, and wraps modulo 2**CNT_W (all-ones -> 0).
- Simultaneous events:
  - The write and the reads of the same index in one cycle are resolved by the bypass rule above.
  - The write edge and an rst_n assertion in the same cycle: reset wins. The entry stays 0 and the count stays 0.
- Reset mid-operation: all state is cleared at once. Writes in flight in MEM/WB are lost; upstream is responsible for flushing.
- X-safety: a register that has never been written reads 0 after reset, never X.

Test Plan:
1. Reset check: assert rst_n=0 mid-cycle with no clock edge -> ReadData1, ReadData2, dbg_data and wb_count are all 0 immediately; after release, reg[1..31] all read 0.
2. ALU write-back: RegWrite=1, MemtoReg=0, ALU_result=0x0000_1234, WriteReg=8, one edge -> dbg_addr=8 gives 0x0000_1234 and wb_count=1. Then a load: MemtoReg=1, MemData=0xDEAD_BEEF, WriteReg=9 -> reg[9]=0xDEAD_BEEF and wb_count=2.
3. Register-0 protection: RegWrite=1, WriteReg=0, ALU_result=0xFFFF_FFFF, with ReadReg1=0 -> ReadData1=0 before and after the edge, wb_valid=0, and wb_count is unchanged.
4. Same-cycle bypass: reg[5]=0x11; drive RegWrite=1, WriteReg=5, ALU_result=0x22, ReadReg1=ReadReg2=5 -> ReadData1=ReadData2=0x22 before the edge while dbg_data=0x11; after the edge dbg_data=0x22. Repeat with BYPASS=0 -> ReadData=0x11 before the edge.
5. Write disabled: RegWrite=0, WriteReg=7, ALU_result=0xAA -> reg[7] is unchanged and wb_count is unchanged. Also check WriteData still equals 0xAA.
6. Counter wrap and reset race: preload wb_count to 0xFFFF_FFFF via 2**32-1 writes (or force in a CNT_W=4 build to 0xF), commit one write -> wb_count=0. Then assert rst_n=0 coincident with a write edge to reg[3]=0x55 -> reg[3]=0 and wb_count=0.
